// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcode map (common with the
// ALU control decoder), multiply/divide sequencer states and iteration count.
package alu_pkg;

   localparam logic [4:0] OP_AND  = 5'b00000;
   localparam logic [4:0] OP_MFLO = 5'b00001;
   localparam logic [4:0] OP_OR   = 5'b00010;
   localparam logic [4:0] OP_LUI  = 5'b00011;
   localparam logic [4:0] OP_ADD  = 5'b00100;
   localparam logic [4:0] OP_XOR  = 5'b00110;
   localparam logic [4:0] OP_SLTI = 5'b00111;
   localparam logic [4:0] OP_MULT = 5'b01000;
   localparam logic [4:0] OP_DIV  = 5'b01010;
   localparam logic [4:0] OP_SUB  = 5'b01100;
   localparam logic [4:0] OP_SLT  = 5'b01110;
   localparam logic [4:0] OP_MFHI = 5'b01111;
   localparam logic [4:0] OP_SLL  = 5'b10000;
   localparam logic [4:0] OP_SRL  = 5'b10010;
   localparam logic [4:0] OP_SRA  = 5'b10100;
   localparam logic [4:0] OP_SLLV = 5'b10110;
   localparam logic [4:0] OP_NOR  = 5'b11000;
   localparam logic [4:0] OP_SRLV = 5'b11001;
   localparam logic [4:0] OP_BNE  = 5'b11010;
   localparam logic [4:0] OP_BLEZ = 5'b11100;
   localparam logic [4:0] OP_BGTZ = 5'b11110;

   localparam int MD_CYCLES = 32;

   typedef enum logic [1:0] {IDLE, ITER, FIX} md_state_t;

   function automatic logic [31:0] magnitude(input logic [31:0] v);
      return v[31] ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative signed multiply (shift-add) / divide (restoring) engine.
// Runs on operand magnitudes; sign correction is applied in the FIX state.
module muldiv_seq
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_div,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        idle,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_t   state;
   logic [4:0]  cnt;
   logic        op_div;
   logic        neg_q;
   logic        neg_r;
   logic        div_zero;
   logic [31:0] opnd;
   logic [31:0] acc;
   logic [31:0] low;

   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic        div_ge;
   logic [31:0] div_rem;
   logic [63:0] prod_fix;

   // acc/low hold {upper, lower} product for mult and {remainder, quotient} for div.
   always_comb begin
      mul_sum   = {1'b0, acc} + (low[0] ? {1'b0, opnd} : 33'd0);
      div_shift = {acc, low[31]};
      div_ge    = div_shift >= {1'b0, opnd};
      div_rem   = div_shift[31:0] - opnd;
      prod_fix  = neg_q ? -{acc, low} : {acc, low};
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         op_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         opnd     <= '0;
         acc      <= '0;
         low      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= ITER;
                  cnt      <= '0;
                  op_div   <= is_div;
                  neg_q    <= a[31] ^ b[31];
                  neg_r    <= a[31];
                  div_zero <= (b == '0);
                  acc      <= '0;
                  opnd     <= is_div ? magnitude(b) : magnitude(a);
                  low      <= is_div ? magnitude(a) : magnitude(b);
               end
            end
            ITER: begin
               if (op_div) begin
                  acc <= div_ge ? div_rem : div_shift[31:0];
                  low <= {low[30:0], div_ge};
               end else begin
                  acc <= mul_sum[32:1];
                  low <= {mul_sum[0], low[31:1]};
               end
               cnt <= cnt + 5'd1;
               if (cnt == 5'(MD_CYCLES - 1)) state <= FIX;
            end
            FIX:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign idle = (state == IDLE);
   assign done = (state == FIX);

   // Divide by zero leaves remainder = |a|, which the dividend-sign fix turns back into a.
   always_comb begin
      if (op_div) begin
         lo = div_zero ? '1 : (neg_q ? -low : low);
         hi = neg_r ? -acc : acc;
      end else begin
         hi = prod_fix[63:32];
         lo = prod_fix[31:0];
      end
   end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle datapath, HI/LO pair and valid/ready
// handshake around the iterative mult/div engine.
module alu_exec
   import alu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [4:0]   alu_ctrl,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [4:0]   shamt,
   output logic         out_valid,
   output logic [W-1:0] result,
   output logic         zero,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo
);

   logic         accept;
   logic         is_md;
   logic         md_idle;
   logic         md_done;
   logic [W-1:0] md_hi;
   logic [W-1:0] md_lo;
   logic [W-1:0] alu_res;
   logic         alu_zero;
   logic         known;

   assign is_md    = (alu_ctrl == OP_MULT) || (alu_ctrl == OP_DIV);
   assign accept   = in_valid && in_ready;
   assign in_ready = md_idle;

   muldiv_seq u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .start  (accept && is_md),
      .is_div (alu_ctrl == OP_DIV),
      .a      (a),
      .b      (b),
      .idle   (md_idle),
      .done   (md_done),
      .hi     (md_hi),
      .lo     (md_lo)
   );

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      alu_res = '0;
      known   = 1'b1;
      case (alu_ctrl)
         OP_AND:          alu_res = a & b;
         OP_OR:           alu_res = a | b;
         OP_XOR:          alu_res = a ^ b;
         OP_NOR:          alu_res = ~(a | b);
         OP_ADD:          alu_res = a + b;
         OP_SUB, OP_BNE:  alu_res = a - b;
         OP_BLEZ,
         OP_BGTZ:         alu_res = a;
         OP_SLT, OP_SLTI: alu_res = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
         OP_LUI:          alu_res = {b[15:0], 16'h0000};
         OP_SLL:          alu_res = b << shamt;
         OP_SRL:          alu_res = b >> shamt;
         OP_SRA:          alu_res = $unsigned($signed(b) >>> shamt);
         OP_SLLV:         alu_res = b << a[4:0];
         OP_SRLV:         alu_res = b >> a[4:0];
         OP_MFHI:         alu_res = hi;
         OP_MFLO:         alu_res = lo;
         default:         known   = 1'b0;
      endcase

      alu_zero = known && (alu_res == '0);
      case (alu_ctrl)
         OP_BNE:  alu_zero = (a != b);
         OP_BLEZ: alu_zero = a[W-1] || (a == '0);
         OP_BGTZ: alu_zero = !a[W-1] && (a != '0);
         default: ;
      endcase
   end

   // A completion and a single-cycle accept never coincide: the engine is not idle in FIX.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         out_valid <= 1'b0;
         if (md_done) begin
            hi        <= md_hi;
            lo        <= md_lo;
            result    <= md_lo;
            zero      <= (md_lo == '0);
            out_valid <= 1'b1;
         end else if (accept && !is_md) begin
            result    <= alu_res;
            zero      <= alu_zero;
            out_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases plus randomized ops
// compared against a 64-bit arithmetic reference model.
module tb_alu_exec;
   import alu_pkg::*;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  alu_ctrl;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  shamt;
   logic        out_valid;
   logic [31:0] result;
   logic        zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_vec;
   int          n_bad;
   logic [31:0] exp_hi;
   logic [31:0] exp_lo;
   logic [31:0] exp_res;
   logic        exp_zero;

   alu_exec #(.W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .a         (a),
      .b         (b),
      .shamt     (shamt),
      .out_valid (out_valid),
      .result    (result),
      .zero      (zero),
      .hi        (hi),
      .lo        (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference model: plain signed 64-bit arithmetic on the architectural rules.
   task automatic model(input logic [4:0] op, input logic [31:0] ra, input logic [31:0] rb,
                        input logic [4:0] sh, output logic [31:0] r, output logic z);
      longint sa;
      longint sb;
      longint p;
      longint q;
      longint rm;
      bit     known;
      sa    = longint'($signed(ra));
      sb    = longint'($signed(rb));
      r     = '0;
      known = 1'b1;
      case (op)
         OP_AND:          r = ra & rb;
         OP_OR:           r = ra | rb;
         OP_XOR:          r = ra ^ rb;
         OP_NOR:          r = ~(ra | rb);
         OP_ADD:          r = 32'(sa + sb);
         OP_SUB, OP_BNE:  r = 32'(sa - sb);
         OP_BLEZ,
         OP_BGTZ:         r = ra;
         OP_SLT, OP_SLTI: r = (sa < sb) ? 32'd1 : 32'd0;
         OP_LUI:          r = 32'(longint'(rb) * 65536);
         OP_SLL:          r = 32'(longint'(rb) * (64'd1 << sh));
         OP_SRL:          r = 32'(longint'(rb) / (64'd1 << sh));
         OP_SRA:          r = 32'(sb >>> sh);
         OP_SLLV:         r = 32'(longint'(rb) * (64'd1 << ra[4:0]));
         OP_SRLV:         r = 32'(longint'(rb) / (64'd1 << ra[4:0]));
         OP_MFHI:         r = exp_hi;
         OP_MFLO:         r = exp_lo;
         OP_MULT: begin
            p      = sa * sb;
            exp_hi = 32'(p >>> 32);
            exp_lo = 32'(p);
            r      = exp_lo;
         end
         OP_DIV: begin
            if (sb == 0) begin
               exp_lo = 32'hFFFF_FFFF;
               exp_hi = ra;
            end else begin
               q      = sa / sb;
               rm     = sa % sb;
               exp_lo = 32'(q);
               exp_hi = 32'(rm);
            end
            r = exp_lo;
         end
         default: known = 1'b0;
      endcase
      z = known && (r == 0);
      case (op)
         OP_SUB:  z = (sa == sb);
         OP_BNE:  z = (sa != sb);
         OP_BLEZ: z = (sa <= 0);
         OP_BGTZ: z = (sa > 0);
         default: ;
      endcase
   endtask

   task automatic run_op(input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input logic [4:0] sh);
      logic [31:0] r;
      logic        z;
      bit          md;
      int          cyc;
      int          lo_cnt;
      md = (op == OP_MULT) || (op == OP_DIV);
      model(op, va, vb, sh, r, z);
      check("ready_before_issue", 64'(in_ready), 64'd1);
      alu_ctrl = op;
      a        = va;
      b        = vb;
      shamt    = sh;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (md) begin
         cyc    = 0;
         lo_cnt = 0;
         while (!out_valid && cyc < 100) begin
            if (!in_ready) lo_cnt++;
            // Offer junk while busy; it must be ignored.
            in_valid = 1'($urandom);
            alu_ctrl = 5'($urandom);
            a        = $urandom;
            b        = $urandom;
            shamt    = 5'($urandom);
            @(posedge clk); #1;
            cyc++;
         end
         in_valid = 1'b0;
         check("md_latency", 64'(cyc), 64'd33);
         check("md_ready_low_cycles", 64'(lo_cnt), 64'd33);
         check("md_ready_back", 64'(in_ready), 64'd1);
      end
      check($sformatf("out_valid op=%b", op), 64'(out_valid), 64'd1);
      check($sformatf("result op=%b a=%h b=%h sh=%0d", op, va, vb, sh), 64'(result), 64'(r));
      check($sformatf("zero op=%b a=%h b=%h", op, va, vb), 64'(zero), 64'(z));
      check("hi", 64'(hi), 64'(exp_hi));
      check("lo", 64'(lo), 64'(exp_lo));
      exp_res  = r;
      exp_zero = z;
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("idle_no_valid", 64'(out_valid), 64'd0);
      check("idle_result_held", 64'(result), 64'(exp_res));
      check("idle_zero_held", 64'(zero), 64'(exp_zero));
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 6))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20)) - 32'd10;
         default: return $urandom;
      endcase
   endfunction

   logic [4:0] codes [21] = '{OP_AND, OP_MFLO, OP_OR, OP_LUI, OP_ADD, OP_XOR, OP_SLTI,
                              OP_MULT, OP_DIV, OP_SUB, OP_SLT, OP_MFHI, OP_SLL, OP_SRL,
                              OP_SRA, OP_SLLV, OP_NOR, OP_SRLV, OP_BNE, OP_BLEZ, OP_BGTZ};

   initial begin
      int         pulses;
      logic [4:0] op;
      n_vec    = 0;
      n_bad    = 0;
      exp_hi   = '0;
      exp_lo   = '0;
      exp_res  = '0;
      exp_zero = 1'b0;
      reset    = 1'b1;
      in_valid = 1'b0;
      alu_ctrl = '0;
      a        = '0;
      b        = '0;
      shamt    = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_result", 64'(result), 64'd0);
      check("rst_zero", 64'(zero), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      reset = 1'b0;
      @(posedge clk); #1;

      // Back-to-back single-cycle ops with in_valid held high.
      run_op(OP_ADD, 32'd7, 32'd5, 5'd0);
      run_op(OP_SUB, 32'd5, 32'd5, 5'd0);
      run_op(OP_SRA, 32'd0, 32'h8000_0000, 5'd4);
      check("sra_literal", 64'(result), 64'h0000_0000_F800_0000);
      idle_cycle();

      run_op(OP_MULT, -32'sd3, 32'd7, 5'd0);
      check("mult_hi_literal", 64'(hi), 64'h0000_0000_FFFF_FFFF);
      check("mult_lo_literal", 64'(lo), 64'h0000_0000_FFFF_FFEB);
      run_op(OP_MFLO, 32'd0, 32'd0, 5'd0);
      check("mflo_literal", 64'(result), 64'h0000_0000_FFFF_FFEB);
      run_op(OP_MFHI, 32'd0, 32'd0, 5'd0);
      idle_cycle();

      run_op(OP_DIV, -32'sd7, 32'd2, 5'd0);
      check("div_lo_literal", 64'(lo), 64'h0000_0000_FFFF_FFFD);
      check("div_hi_literal", 64'(hi), 64'h0000_0000_FFFF_FFFF);
      run_op(OP_DIV, 32'd9, 32'd0, 5'd0);
      check("div0_lo_literal", 64'(lo), 64'h0000_0000_FFFF_FFFF);
      check("div0_hi_literal", 64'(hi), 64'd9);
      run_op(OP_DIV, -32'sd9, 32'd0, 5'd0);
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
      check("divovf_lo_literal", 64'(lo), 64'h0000_0000_8000_0000);
      run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 5'd0);

      run_op(OP_BNE, 32'd1, 32'd2, 5'd0);
      check("bne_zero_literal", 64'(zero), 64'd1);
      run_op(OP_BLEZ, 32'd0, 32'd0, 5'd0);
      check("blez_zero_literal", 64'(zero), 64'd1);
      run_op(OP_BGTZ, 32'h8000_0000, 32'd0, 5'd0);
      check("bgtz_zero_literal", 64'(zero), 64'd0);
      run_op(OP_LUI, 32'd0, 32'h0000_1234, 5'd0);
      check("lui_literal", 64'(result), 64'h0000_0000_1234_0000);
      run_op(5'b00101, 32'd0, 32'd0, 5'd0);
      check("unknown_zero_literal", 64'(zero), 64'd0);
      idle_cycle();

      // Reset in the middle of a divide.
      alu_ctrl = OP_DIV;
      a        = 32'd100;
      b        = 32'd3;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("midrst_result", 64'(result), 64'd0);
      check("midrst_zero", 64'(zero), 64'd0);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_hi", 64'(hi), 64'd0);
      check("midrst_lo", 64'(lo), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      reset    = 1'b0;
      exp_hi   = '0;
      exp_lo   = '0;
      exp_res  = '0;
      exp_zero = 1'b0;
      pulses   = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) pulses++;
      end
      check("midrst_no_completion", 64'(pulses), 64'd0);
      run_op(OP_ADD, 32'd20, 32'd22, 5'd0);

      // Randomized mix, including codes outside the opcode map.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) == 0) op = 5'($urandom);
         else                           op = codes[$urandom_range(0, 20)];
         run_op(op, rnd_val(), rnd_val(), 5'($urandom));
         if ($urandom_range(0, 4) == 0) idle_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
